sub_borrow_pipe: RTL and testbench
==================================

SUB_BORROW_PIPE -- requirements
Module: sub_borrow_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; even, at least 2.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit, operand beat present.
REQ-005 SHALL have port in_ready, output, 1 bit, block accepts operand beat this cycle.
REQ-006 SHALL have ports a and b, input, WIDTH bits each, minuend and subtrahend (unsigned).
REQ-007 SHALL have port bin, input, 1 bit, borrow-in.
REQ-008 SHALL have port out_valid, output, 1 bit, result beat present.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts result this cycle.
REQ-010 SHALL have port diff, output, WIDTH bits, a - b - bin modulo 2^WIDTH.
REQ-011 SHALL have port bout, output, 1 bit, 1 iff a < b + bin (unsigned).

Function
REQ-012 SHALL accept a beat when in_valid and in_ready are both 1 in the same cycle; SHALL emit a beat when out_valid and out_ready are both 1.
REQ-013 SHALL use a two-stage pipeline:
- stage 1: low half (bits WIDTH/2-1..0) with bin; registers low difference, mid borrow and the high operand halves.
- stage 2: high half with the registered mid borrow; registers the full diff and bout.
REQ-014 SHALL assert out_valid exactly 2 cycles after an accepted beat when out_ready is held 1; throughput one beat per cycle.
REQ-015 SHALL advance stage 2 when it is empty or its content is consumed; stage 1 SHALL advance into stage 2 under the same condition.
REQ-016 SHALL drive in_ready = !s1_valid || stage-1 advancing; in_ready SHALL NOT depend on in_valid.
REQ-017 SHALL hold diff, bout and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL keep beat order, and SHALL NOT drop or duplicate beats under any back-pressure pattern.
REQ-019 SHALL propagate the borrow correctly across the half boundary, including the bin=1 ripple through all-zero operands.
REQ-020 SHALL leave diff and bout don't-care while out_valid=0.

Reset
REQ-021 SHALL clear both stage-valid flags on rst, discarding any in-flight beats.
REQ-022 SHALL drive out_valid=0, diff=0, bout=0 and in_ready=1 in the first cycle after rst deasserts.
REQ-023 SHALL give rst priority over a simultaneous accept; a beat offered in the reset cycle is not captured.

Configuration
REQ-024 SHALL, when macro SUB_BORROW_OVF_EN is defined, add output port ovf (1 bit, reset 0).
- ovf = signed two's-complement overflow of a - b - bin.
- ovf is pipelined and held alongside diff.
REQ-025 SHALL, when SUB_BORROW_OVF_EN is undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-026 SHALL take from shared package sub_pkg:
- default width constant SUB_WIDTH_DEF = 8;
- pipeline depth constant SUB_STAGES = 2.
REQ-027 SHALL implement each half as instances of one combinational sub-module sub_borrow_slice.
- ports: x, y, borrow-in; outputs difference and borrow-out.
- internal structure: propagate/generate borrow chain.

Verification
REQ-028 SHALL check: a=0x05, b=0x03, bin=0, out_ready=1 -> diff=0x02, bout=0, out_valid 2 cycles after accept.
REQ-029 SHALL check: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; and a=0x10, b=0x00, bin=1 -> diff=0x0F, bout=0 (cross-half borrow).
REQ-030 SHALL check: three back-to-back beats (1-0, 2-0, 3-0) with out_ready=0 for 4 cycles.
- in_ready drops after two beats are held.
- diff stays 0x01 while stalled.
- after out_ready=1, outputs 0x01, 0x02, 0x03 in order, with no loss.
REQ-031 SHALL check: rst asserted while two beats are in flight -> out_valid=0 next cycle; neither beat ever emitted; in_ready=1 after release.
REQ-032 SHALL check with SUB_BORROW_OVF_EN defined: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1, bout=0; and a=0x7F, b=0x01 -> ovf=0.
REQ-033 SHALL check: random a/b/bin with random out_ready over 10000 beats -> every output matches the reference model in order.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants for the pipelined borrow subtractor.
//   SUB_WIDTH_DEF : default operand/result width
//   SUB_STAGES    : register stages from accepted operand beat to result beat
package sub_pkg;

    localparam int unsigned SUB_WIDTH_DEF = 8;
    localparam int unsigned SUB_STAGES    = 2;

endpackage

// File: rtl/sub_borrow_slice.sv
// Combinational N-bit subtract slice: d = x - y - bi, bo = borrow out.
// Ports:
//   x, y : input  [N-1:0] minuend / subtrahend
//   bi   : input  borrow-in
//   d    : output [N-1:0] difference
//   bo   : output borrow-out
module sub_borrow_slice #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bi,
    output logic [N-1:0] d,
    output logic         bo
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   br;

    // A bit generates a borrow when x=0,y=1; it passes an incoming borrow when x==y.
    assign gen  = ~x & y;
    assign prop = ~(x ^ y);

    // Ripple borrow chain.
    always_comb begin
        br    = '0;
        br[0] = bi;
        for (int unsigned i = 0; i < N; i++) begin
            br[i+1] = gen[i] | (prop[i] & br[i]);
        end
    end

    assign d  = x ^ y ^ br[N-1:0];
    assign bo = br[N];

endmodule

// File: rtl/sub_borrow_pipe.sv
// Two-stage pipelined unsigned subtractor with valid/ready handshakes.
// Stage 1 subtracts the low half with bin; stage 2 subtracts the high half
// with the registered mid borrow and holds the result until consumed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand beat handshake (a, b, bin)
//   out_valid/out_ready : result beat handshake (diff, bout[, ovf])
//   ovf                 : signed overflow, present only with SUB_BORROW_OVF_EN
module sub_borrow_pipe
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SUB_BORROW_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned HALF = WIDTH / 2;

    logic            s1_valid;
    logic [HALF-1:0] s1_dlo;
    logic            s1_bmid;
    logic [HALF-1:0] s1_ahi;
    logic [HALF-1:0] s1_bhi;

    logic [HALF-1:0] dlo;
    logic            blo;
    logic [HALF-1:0] dhi;
    logic            bhi;
    logic            advance;
    logic            accept;

    // Stage 2 can take new content when empty or when its beat leaves this cycle.
    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;

    sub_borrow_slice #(.N(HALF)) u_lo (
        .x  (a[HALF-1:0]),
        .y  (b[HALF-1:0]),
        .bi (bin),
        .d  (dlo),
        .bo (blo)
    );

    sub_borrow_slice #(.N(HALF)) u_hi (
        .x  (s1_ahi),
        .y  (s1_bhi),
        .bi (s1_bmid),
        .d  (dhi),
        .bo (bhi)
    );

    // Stage 1: low-half result, mid borrow and the untouched high halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_dlo   <= '0;
            s1_bmid  <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_dlo   <= dlo;
            s1_bmid  <= blo;
            s1_ahi   <= a[WIDTH-1:HALF];
            s1_bhi   <= b[WIDTH-1:HALF];
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: full result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= {dhi, s1_dlo};
                bout <= bhi;
            end
        end
    end

`ifdef SUB_BORROW_OVF_EN
    // Overflow: operand signs differ and the result sign differs from a's.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (advance && s1_valid) begin
            ovf <= (s1_ahi[HALF-1] ^ s1_bhi[HALF-1]) & (dhi[HALF-1] ^ s1_ahi[HALF-1]);
        end
    end
`endif

endmodule

// File: tb/tb_sub_borrow_pipe.sv
// Self-checking bench for sub_borrow_pipe: directed cases plus a randomized
// run scored against an arithmetic reference model. Define SUB_BORROW_OVF_EN
// to also exercise the ovf output.
module tb_sub_borrow_pipe;
    import sub_pkg::*;

    localparam int unsigned W       = 8;
    localparam int unsigned N_BEATS = 10000;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    sub_borrow_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SUB_BORROW_OVF_EN
        .ovf       (ovf),
`endif
        .diff      (diff),
        .bout      (bout)
    );

`ifndef SUB_BORROW_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        int   ux;
        int   uy;
        int   sx;
        int   sy;
        int   r;
        int   sr;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        r  = ux - uy - int'(c);
        sr = sx - sy - int'(c);
        e.diff = W'((r + (1 << W)) % (1 << W));
        e.bout = (ux < uy + int'(c));
        e.ovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
        return e;
    endfunction

    // Scoreboard and stall-hold monitor, sampled mid-cycle.
    logic         held = 1'b0;
    logic [W-1:0] held_diff;
    logic         held_bout;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_diff", 32'(diff), 32'(held_diff));
                check("hold_bout", 32'(bout), 32'(held_bout));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("sb_diff", 32'(diff), 32'(e.diff));
                    check("sb_bout", 32'(bout), 32'(e.bout));
`ifdef SUB_BORROW_OVF_EN
                    check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
            held      = out_valid && !out_ready;
            held_diff = diff;
            held_bout = bout;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, bin));
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_ready=1; checks latency and result.
    task automatic run1(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W-1:0] ed, input logic eb, input logic eo);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        bin       = c;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < int'(SUB_STAGES); k++) begin
            @(negedge clk);
            check({tag, "_early"}, 32'(out_valid), 32'd0);
            step();
        end
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SUB_BORROW_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) begin end
`endif
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        run1("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run1("wrap", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run1("xhalf", 8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0);
        run1("ripple", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run1("ovf_pos", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run1("ovf_neg", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);

        // Back-pressure: three beats against a stalled consumer.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h00; bin = 1'b0;
        step(); a = 8'h02;
        step(); a = 8'h03;
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_diff_t2", 32'(diff), 32'h01);
        step();
        @(negedge clk);
        check("bp_in_ready_low2", 32'(in_ready), 32'd0);
        check("bp_diff_t3", 32'(diff), 32'h01);
        step(); out_ready = 1'b1;
        @(negedge clk);
        check("bp_out1", 32'(diff), 32'h01);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2", 32'(diff), 32'h02);
        step();
        @(negedge clk);
        check("bp_out3_valid", 32'(out_valid), 32'd1);
        check("bp_out3", 32'(diff), 32'h03);
        step();

        // Reset with two beats in flight, plus a beat offered during reset.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h09; b = 8'h01;
        step(); a = 8'h07;
        step(); rst = 1'b1; a = 8'h55;
        step(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("flush_no_emit", 32'(out_valid), 32'd0);
        end
        step();

        // Randomized traffic with random back-pressure.
        acc0 = n_acc;
        cyc  = 0;
        while ((n_acc - acc0) < int'(N_BEATS) && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            cyc++;
        end
        check("rand_beats", 32'(n_acc - acc0 >= int'(N_BEATS)), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || out_valid) && cyc < 20) begin
            step();
            cyc++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
